// File: rtl/ma_injector_pkg.sv
// Shared types and constants for the MA stream injector.
// Header sizes follow the loader file layout word for word.
package ma_injector_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    BODY,
    D_CNT0,
    D_CNT1,
    D_MAP0,
    D_TTT0,
    D_PAIRS,
    D_NULL,
    FIN
  } state_t;

  localparam int HDR_WORDS      = 4;
  localparam int DESC_HDR_WORDS = 2;

endpackage

// File: rtl/noc_tx_reg.sv
// One-entry NoC output register, 1 cycle latency, full rate under continuous credit.
// Holds data_o/tx_o while tx_o&!credit_i; in_rdy_o = !tx_o || credit_i.
module noc_tx_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         tx_o,
  input  logic         credit_i,
  output logic [W-1:0] data_o
);

  logic         tx_q, tx_d;
  logic [W-1:0] data_q, data_d;
  logic         rdy;

  assign rdy      = !tx_q || credit_i;
  assign in_rdy_o = rdy;
  assign tx_o     = tx_q;
  assign data_o   = data_q;

  always_comb begin
    tx_d   = tx_q;
    data_d = data_q;
    if (rdy) begin
      tx_d = in_vld_i;
      if (in_vld_i) data_d = in_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q   <= 1'b0;
      data_q <= '0;
    end else begin
      tx_q   <= tx_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/ma_stream_injector.sv
// MA injector: mapper image, generated descriptor, then remaining images onto the NoC.
// Stream word accepted at edge N is on data_o after N; src_ready_o follows output-register space.
module ma_stream_injector
  import ma_injector_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     task_cnt_i,
  input  logic [ADDR_W-1:0]    mapper_address_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [FLIT_SIZE-1:0] src_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     img_q, img_d;
  logic [FLIT_SIZE-1:0] wcnt_q, wcnt_d;
  logic [FLIT_SIZE-1:0] text_q, text_d;
  logic [FLIT_SIZE-1:0] len_q, len_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic                 reg_rdy;
  logic                 consume;
  logic                 gen;
  logic                 fire;
  logic                 end_image;
  logic [FLIT_SIZE-1:0] out_dat;
  logic [FLIT_SIZE:0]   sum;

  assign sum         = {1'b0, text_q} + {1'b0, src_data_i};
  assign fire        = reg_rdy && (gen || (consume && src_valid_i));
  assign src_ready_o = consume && reg_rdy;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Source of the next flit depends on the state alone, keeping fire free of loops.
  always_comb begin
    consume = 1'b0;
    gen     = 1'b0;
    out_dat = src_data_i;
    case (state_q)
      HDR, BODY, D_TTT0, D_PAIRS: consume = 1'b1;
      D_CNT0, D_CNT1: begin
        gen     = 1'b1;
        out_dat = FLIT_SIZE'(cnt_q);
      end
      D_MAP0: begin
        gen     = 1'b1;
        out_dat = FLIT_SIZE'(addr_q);
      end
      D_NULL: begin
        gen     = 1'b1;
        out_dat = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    img_d     = img_q;
    wcnt_d    = wcnt_q;
    text_d    = text_q;
    len_d     = len_q;
    err_d     = err_q;
    done_d    = 1'b0;
    end_image = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d  = task_cnt_i;
          addr_d = mapper_address_i;
          img_d  = '0;
          wcnt_d = '0;
          err_d  = (task_cnt_i == '0);
          if (task_cnt_i == '0) done_d = 1'b1;
          else                  state_d = HDR;
        end
      end
      HDR: begin
        if (fire) begin
          wcnt_d = wcnt_q + FLIT_SIZE'(1);
          if (wcnt_q == '0) text_d = src_data_i;
          if (wcnt_q == FLIT_SIZE'(1)) begin
            len_d = {1'b0, sum[FLIT_SIZE:2]};
            if (sum[1:0] != 2'b00) err_d = 1'b1;
          end
          if (wcnt_q == FLIT_SIZE'(HDR_WORDS - 1)) begin
            wcnt_d = '0;
            if (len_q == '0) end_image = 1'b1;
            else             state_d   = BODY;
          end
        end
      end
      BODY: begin
        if (fire) begin
          wcnt_d = wcnt_q + FLIT_SIZE'(1);
          if (wcnt_q == len_q - FLIT_SIZE'(1)) begin
            wcnt_d    = '0;
            end_image = 1'b1;
          end
        end
      end
      D_CNT0: if (fire) state_d = D_CNT1;
      D_CNT1: if (fire) state_d = D_MAP0;
      D_MAP0: if (fire) state_d = D_TTT0;
      D_TTT0: begin
        if (fire) begin
          wcnt_d  = '0;
          state_d = (cnt_q == CNT_W'(1)) ? D_NULL : D_PAIRS;
        end
      end
      D_PAIRS: begin
        if (fire) begin
          wcnt_d = wcnt_q + FLIT_SIZE'(1);
          if (wcnt_q == (FLIT_SIZE'(cnt_q - CNT_W'(1)) << 1) - FLIT_SIZE'(1)) begin
            wcnt_d  = '0;
            state_d = D_NULL;
          end
        end
      end
      D_NULL: begin
        if (fire) begin
          wcnt_d = wcnt_q + FLIT_SIZE'(1);
          if (wcnt_q == FLIT_SIZE'(cnt_q) - FLIT_SIZE'(1)) begin
            wcnt_d  = '0;
            state_d = (cnt_q > CNT_W'(1)) ? HDR : FIN;
          end
        end
      end
      FIN: begin
        if (reg_rdy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Image 0 is always the mapper; the descriptor goes out right behind it.
    if (end_image) begin
      img_d = img_q + CNT_W'(1);
      if (img_q == '0)                      state_d = D_CNT0;
      else if (img_q == cnt_q - CNT_W'(1))  state_d = FIN;
      else                                  state_d = HDR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      img_q   <= '0;
      wcnt_q  <= '0;
      text_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      img_q   <= img_d;
      wcnt_q  <= wcnt_d;
      text_q  <= text_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  noc_tx_reg #(.W(FLIT_SIZE)) u_tx_reg (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_vld_i (fire),
    .in_rdy_o (reg_rdy),
    .in_dat_i (out_dat),
    .tx_o     (tx_o),
    .credit_i (credit_i),
    .data_o   (data_o)
  );

endmodule

// File: tb/tb_ma_stream_injector.sv
// Directed scenario table plus hand sequences for zero count and mid-transfer reset.
module tb_ma_stream_injector;
  import ma_injector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tcnt = '0;
  logic [15:0] addr = '0;
  logic        sv = 1'b0;
  logic        sr;
  logic [31:0] sd = '0;
  logic        tx;
  logic        credit = 1'b0;
  logic [31:0] dout;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ma_stream_injector #(.FLIT_SIZE(32), .CNT_W(8), .ADDR_W(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .task_cnt_i       (tcnt),
    .mapper_address_i (addr),
    .src_valid_i      (sv),
    .src_ready_o      (sr),
    .src_data_i       (sd),
    .tx_o             (tx),
    .credit_i         (credit),
    .data_o           (dout),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err)
  );

  typedef struct {
    int          cnt;
    logic [15:0] addr;
    int          t0, t1, t2;
    int          d0, d1, d2;
    int          flits;
    bit          err;
    int          cpct;
    int          vpct;
    bit          nobub;
    bit          glitch;
    int          abort;
  } vec_t;

  vec_t        vt[8];
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"},    32'(tx),   0);
    chk({tag, "_data"},  dout,      0);
    chk({tag, "_ready"}, 32'(sr),   0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err),  0);
  endtask

  task automatic setv(input int i, input int c, input int a,
                      input int t0, input int t1, input int t2,
                      input int d0, input int d1, input int d2,
                      input int fl, input bit e, input int cp, input int vp,
                      input bit nb, input bit gl, input int ab);
    vt[i].cnt = c;   vt[i].addr = 16'(a);
    vt[i].t0 = t0;   vt[i].t1 = t1;   vt[i].t2 = t2;
    vt[i].d0 = d0;   vt[i].d1 = d1;   vt[i].d2 = d2;
    vt[i].flits = fl; vt[i].err = e;
    vt[i].cpct = cp; vt[i].vpct = vp;
    vt[i].nobub = nb; vt[i].glitch = gl; vt[i].abort = ab;
  endtask

  task automatic push_both(input logic [31:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Loader file order: image 0, TTT/pair words, then images 1..cnt-1.
  task automatic build(input vec_t v);
    int tt[3];
    int dd[3];
    int len;
    tt[0] = v.t0; tt[1] = v.t1; tt[2] = v.t2;
    dd[0] = v.d0; dd[1] = v.d1; dd[2] = v.d2;
    src_q.delete();
    exp_q.delete();
    for (int k = 0; k < v.cnt; k++) begin
      push_both(32'(tt[k]));
      push_both(32'(dd[k]));
      push_both(32'h0000_1000 + 32'(k));
      push_both(32'h0000_2000 + 32'(k));
      len = (tt[k] + dd[k]) >> 2;
      for (int i = 0; i < len; i++) push_both(32'hB000_0000 | (32'(k) << 16) | 32'(i));
      if (k == 0) begin
        for (int i = 0; i < DESC_HDR_WORDS; i++) exp_q.push_back(32'(v.cnt));
        exp_q.push_back({16'h0, v.addr});
        push_both(32'h7770_0000);
        for (int j = 0; j < 2 * (v.cnt - 1); j++) push_both(32'h5000_0000 + 32'(j));
        for (int j = 0; j < v.cnt; j++) exp_q.push_back(32'h0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc = 0;
    int          acc = 0;
    int          last_acc = -10;
    int          bub = 0;
    bit          took = 1'b0;
    bit          fin = 1'b0;
    bit          first_tx = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    build(v);
    @(posedge clk); #1;
    start  = 1'b1;
    tcnt   = 8'(v.cnt);
    addr   = v.addr;
    credit = ($urandom_range(99) < v.cpct);
    sv     = 1'b0;
    if (src_q.size() > 0 && $urandom_range(99) < v.vpct) begin
      sv = 1'b1;
      sd = src_q[0];
    end
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (v.abort != 0 && cyc == v.abort) begin
        rst_n = 1'b0;
        #1;
        chk_reset($sformatf("v%0d_midreset", idx));
        #1;
        rst_n  = 1'b1;
        sv     = 1'b0;
        credit = 1'b0;
        start  = 1'b0;
        return;
      end
      if (cyc == 2) begin
        chk($sformatf("v%0d_busy_after_start", idx), 32'(busy), 1);
        chk($sformatf("v%0d_err_cleared", idx), 32'(err), 0);
      end
      if (prev_stall) begin
        chk($sformatf("v%0d_stall_tx", idx), 32'(tx), 1);
        chk($sformatf("v%0d_stall_data", idx), dout, prev_dat);
      end
      prev_stall = tx && !credit;
      prev_dat   = dout;
      if (tx) first_tx = 1'b1;
      else if (first_tx && exp_q.size() > 0) bub++;
      if (tx && credit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d_extra_flit: got 0x%0h expected no flit", idx, dout);
        end else begin
          chk($sformatf("v%0d_flit%0d", idx, acc), dout, exp_q.pop_front());
        end
        acc++;
        last_acc = cyc;
      end
      took = sv && sr;
      if (took) void'(src_q.pop_front());
      if (done) begin
        fin = 1'b1;
        chk($sformatf("v%0d_done_timing", idx), 32'(cyc), 32'(last_acc + 1));
        chk($sformatf("v%0d_flit_count", idx), 32'(acc), 32'(v.flits));
        chk($sformatf("v%0d_err_final", idx), 32'(err), 32'(v.err));
        chk($sformatf("v%0d_busy_clear", idx), 32'(busy), 0);
        chk($sformatf("v%0d_tx_idle", idx), 32'(tx), 0);
        chk($sformatf("v%0d_src_consumed", idx), 32'(src_q.size()), 0);
        if (v.nobub) chk($sformatf("v%0d_bubbles", idx), 32'(bub), 0);
      end else if (cyc > 1500) begin
        checks++;
        errors++;
        $display("FAIL v%0d_timeout: got no done after %0d cycles, required done", idx, cyc);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        start = v.glitch && (cyc == 5);
        if (start) tcnt = 8'd7;
        if (took) sv = 1'b0;
        if (!sv && src_q.size() > 0 && $urandom_range(99) < v.vpct) begin
          sv = 1'b1;
          sd = src_q[0];
        end
        credit = ($urandom_range(99) < v.cpct);
      end
    end
    @(posedge clk); #1;
    sv     = 1'b0;
    credit = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse_end", idx), 32'(done), 0);
  endtask

  initial begin
    //      i cnt addr    t0 t1 t2  d0 d1 d2 flits err cp  vp  nb gl abort
    setv(0, 1, 16'h0101,  8, 0, 0,  4, 0, 0, 12, 0, 100, 100, 1, 0, 0);
    setv(1, 3, 16'h0203,  4, 0, 12, 4, 0, 8, 30, 0, 100, 100, 1, 0, 0);
    setv(2, 3, 16'h0203,  4, 0, 12, 4, 0, 8, 30, 0, 50,  60,  0, 1, 0);
    setv(3, 1, 16'h0001,  6, 0, 0,  4, 0, 0, 11, 1, 70,  80,  0, 0, 0);
    setv(4, 2, 16'h00FF, 16, 3, 0,  0, 1, 0, 21, 0, 50,  50,  0, 0, 0);
    setv(5, 3, 16'h0A0B,  0, 0, 2,  0, 0, 1, 23, 1, 60,  60,  0, 0, 0);
    setv(6, 3, 16'h0C0D, 17, 0, 0, 16, 0, 0,  0, 0, 100, 100, 0, 0, 9);
    setv(7, 1, 16'hBEEF,  8, 0, 0,  4, 0, 0, 12, 0, 40,  70,  0, 0, 0);

    #2;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero task count: error and done pulse, nothing on the NoC.
    @(posedge clk); #1;
    start = 1'b1;
    tcnt  = 8'd0;
    addr  = 16'h1234;
    credit = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cnt0_done", 32'(done), 1);
    chk("cnt0_err", 32'(err), 1);
    chk("cnt0_tx", 32'(tx), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("cnt0_done_low%0d", i), 32'(done), 0);
      chk($sformatf("cnt0_tx_low%0d", i), 32'(tx), 0);
      chk($sformatf("cnt0_busy_low%0d", i), 32'(busy), 0);
      chk($sformatf("cnt0_err_hold%0d", i), 32'(err), 1);
    end
    credit = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
